// File: rtl/lsu_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl_if
// Bundles the execute-side request handshake, the writeback-side result
// handshake and the word-addressed memory bus of the load/store unit.
//   master : the load/store controller's view (drives o_*, samples i_*)
//   slave  : the surrounding pipeline / memory view (drives i_*, samples o_*)
// Signals:
//   i_valid/o_ready, i_ren, i_wen, i_addr, i_wdata, i_type : execute side
//   o_valid/i_ready, o_rdata, o_err                        : writeback side
//   o_mem_req/i_mem_gnt, o_mem_we, o_mem_addr, o_mem_wdata,
//   o_mem_wmask, i_mem_rvalid, i_mem_rdata, i_mem_err      : memory bus
// ---------------------------------------------------------------------------
interface lsu_bus_ctrl_if;
    logic        i_valid;
    logic        o_ready;
    logic        i_ren;
    logic        i_wen;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [2:0]  i_type;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_mem_req;
    logic        i_mem_gnt;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        i_mem_err;

    modport master (
        input  i_valid, i_ren, i_wen, i_addr, i_wdata, i_type, i_ready,
               i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_mem_err,
        output o_ready, o_valid, o_rdata, o_err, o_mem_req, o_mem_we,
               o_mem_addr, o_mem_wdata, o_mem_wmask
    );

    modport slave (
        output i_valid, i_ren, i_wen, i_addr, i_wdata, i_type, i_ready,
               i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_mem_err,
        input  o_ready, o_valid, o_rdata, o_err, o_mem_req, o_mem_we,
               o_mem_addr, o_mem_wdata, o_mem_wmask
    );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl
// Multi-cycle load/store unit. Takes one memory operation from execute,
// runs it over a request/grant/response word bus with byte-lane alignment,
// store masking and load sign/zero extension, and hands the result to
// writeback. Misalignment, invalid funct3, bus errors and timeouts all
// collapse into o_err.
// Ports:
//   i_clock : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : lsu_bus_ctrl_if.master (execute, writeback and memory bus)
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed in REQ+WAIT before aborting (1..255)
// ---------------------------------------------------------------------------
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           i_clock,
    input  logic           i_reset,
    lsu_bus_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    // Counter value at the start of the last permitted REQ/WAIT cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_r;
    logic [7:0]  tmo_cnt_r;
    logic        ren_r;
    logic [2:0]  type_r;
    logic [1:0]  lane_r;
    logic        ready_r;
    logic        valid_r;
    logic        err_r;
    logic [31:0] rdata_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_wmask_r;

    logic        acc_noop_s;
    logic        acc_err_s;
    logic [31:0] st_wdata_s;
    logic [3:0]  st_wmask_s;
    logic [31:0] ld_data_s;
    logic        tmo_hit_s;

    // Operation is rejected before touching the bus: both directions,
    // funct3 not defined for the direction, or address not size-aligned.
    function automatic logic op_error_f(input logic ren, input logic wen,
                                        input logic [2:0] ty, input logic [1:0] a);
        logic e;
        e = 1'b0;
        if (ren && wen) begin
            e = 1'b1;
        end else if (ren) begin
            case (ty)
                F3_B, F3_BU: e = 1'b0;
                F3_H, F3_HU: e = a[0];
                F3_W:        e = (a != 2'b00);
                default:     e = 1'b1;
            endcase
        end else if (wen) begin
            case (ty)
                F3_B:    e = 1'b0;
                F3_H:    e = a[0];
                F3_W:    e = (a != 2'b00);
                default: e = 1'b1;
            endcase
        end else begin
            e = 1'b0;
        end
        return e;
    endfunction

    // Replicate store data across lanes so the strobes alone pick the target.
    function automatic logic [31:0] store_wdata_f(input logic [2:0] ty, input logic [31:0] wd);
        logic [31:0] r;
        case (ty)
            F3_B:    r = {4{wd[7:0]}};
            F3_H:    r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Byte-lane strobes for a store of the given size at lane a.
    function automatic logic [3:0] store_wmask_f(input logic [2:0] ty, input logic [1:0] a);
        logic [3:0] m;
        case (ty)
            F3_B: begin
                case (a)
                    2'd0:    m = 4'b0001;
                    2'd1:    m = 4'b0010;
                    2'd2:    m = 4'b0100;
                    default: m = 4'b1000;
                endcase
            end
            F3_H:    m = a[1] ? 4'b1100 : 4'b0011;
            F3_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Pick the addressed lane out of the read word and extend it.
    function automatic logic [31:0] load_extract_f(input logic [2:0] ty, input logic [1:0] a,
                                                   input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (ty)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'h000000, b};
            F3_HU:   r = {16'h0000, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Decode the offered operation and pre-compute lane data for both directions.
    always_comb begin
        acc_noop_s = !bus.i_ren && !bus.i_wen;
        acc_err_s  = op_error_f(bus.i_ren, bus.i_wen, bus.i_type, bus.i_addr[1:0]);
        st_wdata_s = store_wdata_f(bus.i_type, bus.i_wdata);
        st_wmask_s = store_wmask_f(bus.i_type, bus.i_addr[1:0]);
        ld_data_s  = load_extract_f(type_r, lane_r, bus.i_mem_rdata);
        tmo_hit_s  = (tmo_cnt_r >= TMO_LAST);
    end

    // Control FSM with all outputs registered; reset abandons any transfer.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            tmo_cnt_r   <= 8'd0;
            ren_r       <= 1'b0;
            type_r      <= 3'd0;
            lane_r      <= 2'd0;
            ready_r     <= 1'b1;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= 32'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            mem_wmask_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_valid && ready_r) begin
                        ren_r   <= bus.i_ren;
                        type_r  <= bus.i_type;
                        lane_r  <= bus.i_addr[1:0];
                        ready_r <= 1'b0;
                        if (acc_noop_s || acc_err_s) begin
                            state_r <= ST_DONE;
                            valid_r <= 1'b1;
                            err_r   <= acc_err_s;
                            rdata_r <= 32'd0;
                        end else begin
                            state_r     <= ST_REQ;
                            tmo_cnt_r   <= 8'd0;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= bus.i_wen;
                            mem_addr_r  <= {bus.i_addr[31:2], 2'b00};
                            mem_wdata_r <= bus.i_wen ? st_wdata_s : 32'd0;
                            mem_wmask_r <= bus.i_wen ? st_wmask_s : 4'd0;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // A grant in the final allowed cycle still wins over the timeout.
                    if (bus.i_mem_gnt) begin
                        state_r   <= ST_WAIT;
                        mem_req_r <= 1'b0;
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end else if (tmo_hit_s) begin
                        state_r   <= ST_DONE;
                        mem_req_r <= 1'b0;
                        valid_r   <= 1'b1;
                        err_r     <= 1'b1;
                        rdata_r   <= 32'd0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_mem_rvalid) begin
                        state_r <= ST_DONE;
                        valid_r <= 1'b1;
                        if (bus.i_mem_err) begin
                            err_r   <= 1'b1;
                            rdata_r <= 32'd0;
                        end else begin
                            err_r   <= 1'b0;
                            rdata_r <= ren_r ? ld_data_s : 32'd0;
                        end
                    end else if (tmo_hit_s) begin
                        state_r <= ST_DONE;
                        valid_r <= 1'b1;
                        err_r   <= 1'b1;
                        rdata_r <= 32'd0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    // Result held until consumed; acceptance resumes from IDLE only.
                    if (bus.i_ready) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    ready_r   <= 1'b1;
                    valid_r   <= 1'b0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready     = ready_r;
    assign bus.o_valid     = valid_r;
    assign bus.o_err       = err_r;
    assign bus.o_rdata     = rdata_r;
    assign bus.o_mem_req   = mem_req_r;
    assign bus.o_mem_we    = mem_we_r;
    assign bus.o_mem_addr  = mem_addr_r;
    assign bus.o_mem_wdata = mem_wdata_r;
    assign bus.o_mem_wmask = mem_wmask_r;
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_ctrl
// Self-checking bench for lsu_bus_ctrl. A transaction-level reference model
// (alignment rules, lane arithmetic, extension) sets per-cycle expectations
// that a single compare process checks at every falling edge. A second
// instance with a 4-cycle timeout exercises the abort path.
// ---------------------------------------------------------------------------
module tb_lsu_bus_ctrl;
    logic clk;
    logic rst;

    lsu_bus_ctrl_if bif();
    lsu_bus_ctrl_if tif();

    lsu_bus_ctrl #(.TIMEOUT_CYCLES(12)) u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bif)
    );

    lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) u_dut_t4 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (tif)
    );

    int n_err    = 0;
    int n_checks = 0;

    logic        chk_en = 1'b0;
    logic        e_ready, e_valid, e_err, e_req, e_we;
    logic [31:0] e_rdata, e_maddr, e_mwdata;
    logic [3:0]  e_wmask;

    // random-loop scratch
    logic        r_ren, r_wen, r_merr;
    logic [2:0]  r_ty;
    logic [31:0] r_addr, r_wd, r_word;
    int          r_g, r_r, r_d, r_sel;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic mdl_err(input logic ren, input logic wen,
                                     input logic [2:0] ty, input logic [31:0] addr);
        int unsigned bytes;
        bit legal;
        if (!ren && !wen) return 1'b0;
        if (ren && wen) return 1'b1;
        legal = ren ? (ty inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (ty inside {3'd0, 3'd1, 3'd2});
        if (!legal) return 1'b1;
        bytes = 32'd1 << ty[1:0];
        return (addr % bytes) != 32'd0;
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [2:0] ty, input logic [31:0] wd);
        case (ty[1:0])
            2'd0:    return {24'h0, wd[7:0]} * 32'h01010101;
            2'd1:    return {16'h0, wd[15:0]} * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] mdl_wmask(input logic [2:0] ty, input logic [1:0] a);
        case (ty[1:0])
            2'd0:    return 4'b0001 << a;
            2'd1:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] ty, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] s;
        s = w >> (32'd8 * {30'd0, a});
        case (ty)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd4:    return {24'h0, s[7:0]};
            3'd5:    return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(bif.o_ready), 32'(e_ready));
            chk("valid", 32'(bif.o_valid), 32'(e_valid));
            chk("mem_req", 32'(bif.o_mem_req), 32'(e_req));
            if (e_valid) begin
                chk("rdata", bif.o_rdata, e_rdata);
                chk("err", 32'(bif.o_err), 32'(e_err));
            end
            if (e_req) begin
                chk("mem_addr", bif.o_mem_addr, e_maddr);
                chk("mem_we", 32'(bif.o_mem_we), 32'(e_we));
                chk("mem_wmask", 32'(bif.o_mem_wmask), 32'(e_wmask));
                if (e_we) chk("mem_wdata", bif.o_mem_wdata, e_mwdata);
            end
        end
    end

    // Execute-side inputs scrambled while the unit is busy; they must be ignored.
    task automatic junk_exec();
        bif.i_valid = 1'($urandom_range(0, 1));
        bif.i_ren   = 1'($urandom_range(0, 1));
        bif.i_wen   = 1'($urandom_range(0, 1));
        bif.i_type  = 3'($urandom_range(0, 7));
        bif.i_addr  = $urandom;
        bif.i_wdata = $urandom;
    endtask

    task automatic run_op(input logic ren, input logic wen, input logic [2:0] ty,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int g, input int r, input int d,
                          input logic [31:0] rword, input logic merr,
                          input bit lit_en, input logic [31:0] lit_maddr,
                          input logic [31:0] lit_mwdata, input logic [3:0] lit_wmask,
                          input logic [31:0] lit_rdata, input logic lit_err);
        logic pre_err;
        logic bus_op;
        pre_err = mdl_err(ren, wen, ty, addr);
        bus_op  = (ren || wen) && !pre_err;
        bif.i_valid = 1'b1;
        bif.i_ren   = ren;
        bif.i_wen   = wen;
        bif.i_type  = ty;
        bif.i_addr  = addr;
        bif.i_wdata = wd;
        e_ready = 1'b1;
        e_valid = 1'b0;
        e_req   = 1'b0;
        @(posedge clk); #1;
        junk_exec();
        e_ready = 1'b0;
        if (bus_op) begin
            e_req    = 1'b1;
            e_we     = wen;
            e_maddr  = {addr[31:2], 2'b00};
            e_mwdata = mdl_wdata(ty, wd);
            e_wmask  = wen ? mdl_wmask(ty, addr[1:0]) : 4'b0000;
            for (int k = 0; k <= g; k++) begin
                bif.i_mem_gnt    = (k == g);
                bif.i_mem_rvalid = 1'($urandom_range(0, 1));
                bif.i_mem_rdata  = $urandom;
                bif.i_mem_err    = 1'($urandom_range(0, 1));
                if (lit_en && k == 0) begin
                    chk("lit_mem_addr", bif.o_mem_addr, lit_maddr);
                    chk("lit_mem_wmask", 32'(bif.o_mem_wmask), 32'(lit_wmask));
                    if (wen) chk("lit_mem_wdata", bif.o_mem_wdata, lit_mwdata);
                end
                @(posedge clk); #1;
                junk_exec();
            end
            e_req = 1'b0;
            for (int k = 0; k <= r; k++) begin
                bif.i_mem_gnt    = 1'($urandom_range(0, 1));
                bif.i_mem_rvalid = (k == r);
                bif.i_mem_rdata  = (k == r) ? rword : $urandom;
                bif.i_mem_err    = (k == r) ? merr : 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                junk_exec();
            end
            bif.i_mem_rvalid = 1'b0;
            bif.i_mem_gnt    = 1'b0;
            e_err   = merr;
            e_rdata = (merr || !ren) ? 32'd0 : mdl_load(ty, addr[1:0], rword);
        end else begin
            e_err   = pre_err;
            e_rdata = 32'd0;
        end
        e_valid = 1'b1;
        for (int k = 0; k <= d; k++) begin
            bif.i_ready     = (k == d);
            bif.i_mem_rdata = $urandom;
            if (lit_en && k == 0) begin
                chk("lit_rdata", bif.o_rdata, lit_rdata);
                chk("lit_err", 32'(bif.o_err), 32'(lit_err));
            end
            @(posedge clk); #1;
            junk_exec();
        end
        bif.i_ready      = 1'b0;
        bif.i_valid      = 1'b0;
        bif.i_mem_rvalid = 1'b0;
        bif.i_mem_gnt    = 1'b0;
        e_valid = 1'b0;
        e_ready = 1'b1;
    endtask

    // Short-timeout instance: LW with scripted grant/response timing.
    task automatic t4_op(input int n_req, input bit gnt_last, input int n_wait,
                         input bit rv_last, input logic exp_err, input logic [31:0] exp_rdata);
        tif.i_valid = 1'b1;
        tif.i_ren   = 1'b1;
        tif.i_wen   = 1'b0;
        tif.i_type  = 3'b010;
        tif.i_addr  = 32'h0000_0100;
        @(posedge clk); #1;
        tif.i_valid = 1'b0;
        for (int k = 0; k < n_req; k++) begin
            chk("t4_req_phase_req", 32'(tif.o_mem_req), 32'd1);
            chk("t4_req_phase_valid", 32'(tif.o_valid), 32'd0);
            tif.i_mem_gnt = gnt_last && (k == n_req - 1);
            @(posedge clk); #1;
        end
        tif.i_mem_gnt = 1'b0;
        for (int k = 0; k < n_wait; k++) begin
            chk("t4_wait_phase_req", 32'(tif.o_mem_req), 32'd0);
            chk("t4_wait_phase_valid", 32'(tif.o_valid), 32'd0);
            tif.i_mem_rvalid = rv_last && (k == n_wait - 1);
            tif.i_mem_rdata  = 32'hCAFE_0123;
            @(posedge clk); #1;
        end
        tif.i_mem_rvalid = 1'b0;
        chk("t4_done_valid", 32'(tif.o_valid), 32'd1);
        chk("t4_done_err", 32'(tif.o_err), 32'(exp_err));
        chk("t4_done_rdata", tif.o_rdata, exp_rdata);
        chk("t4_done_req", 32'(tif.o_mem_req), 32'd0);
        tif.i_ready = 1'b1;
        @(posedge clk); #1;
        tif.i_ready = 1'b0;
        chk("t4_back_idle_ready", 32'(tif.o_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bif.i_valid = 1'b0; bif.i_ren = 1'b0; bif.i_wen = 1'b0; bif.i_addr = 32'd0;
        bif.i_wdata = 32'd0; bif.i_type = 3'd0; bif.i_ready = 1'b0; bif.i_mem_gnt = 1'b0;
        bif.i_mem_rvalid = 1'b0; bif.i_mem_rdata = 32'd0; bif.i_mem_err = 1'b0;
        tif.i_valid = 1'b0; tif.i_ren = 1'b0; tif.i_wen = 1'b0; tif.i_addr = 32'd0;
        tif.i_wdata = 32'd0; tif.i_type = 3'd0; tif.i_ready = 1'b0; tif.i_mem_gnt = 1'b0;
        tif.i_mem_rvalid = 1'b0; tif.i_mem_rdata = 32'd0; tif.i_mem_err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(bif.o_ready), 32'd1);
        chk("rst_valid", 32'(bif.o_valid), 32'd0);
        chk("rst_err", 32'(bif.o_err), 32'd0);
        chk("rst_rdata", bif.o_rdata, 32'd0);
        chk("rst_mem_req", 32'(bif.o_mem_req), 32'd0);
        chk("rst_mem_we", 32'(bif.o_mem_we), 32'd0);
        chk("rst_mem_addr", bif.o_mem_addr, 32'd0);
        chk("rst_mem_wdata", bif.o_mem_wdata, 32'd0);
        chk("rst_mem_wmask", 32'(bif.o_mem_wmask), 32'd0);
        chk("rst_t4_ready", 32'(tif.o_ready), 32'd1);
        rst = 1'b0;
        e_ready = 1'b1; e_valid = 1'b0; e_req = 1'b0; e_we = 1'b0; e_err = 1'b0;
        e_rdata = 32'd0; e_maddr = 32'd0; e_mwdata = 32'd0; e_wmask = 4'd0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // directed operations with hand-computed expectations
        run_op(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'd0, 0, 0, 0, 32'hDEAD_BEEF, 1'b0,
               1'b1, 32'h8000_0004, 32'd0, 4'b0000, 32'hDEAD_BEEF, 1'b0);
        run_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0, 0, 0, 0, 32'h80FF_7F01, 1'b0,
               1'b1, 32'h8000_0000, 32'd0, 4'b0000, 32'hFFFF_FF80, 1'b0);
        run_op(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'd0, 0, 0, 0, 32'h80FF_7F01, 1'b0,
               1'b1, 32'h8000_0000, 32'd0, 4'b0000, 32'h0000_0080, 1'b0);
        run_op(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'd0, 0, 0, 0, 32'h80FF_7F01, 1'b0,
               1'b1, 32'h8000_0000, 32'd0, 4'b0000, 32'hFFFF_80FF, 1'b0);
        run_op(1'b0, 1'b1, 3'b000, 32'h1000_0001, 32'h1234_5678, 0, 0, 0, 32'h7777_7777, 1'b0,
               1'b1, 32'h1000_0000, 32'h7878_7878, 4'b0010, 32'd0, 1'b0);
        run_op(1'b0, 1'b1, 3'b001, 32'h1000_0002, 32'h1234_5678, 0, 0, 0, 32'h7777_7777, 1'b0,
               1'b1, 32'h1000_0000, 32'h5678_5678, 4'b1100, 32'd0, 1'b0);
        run_op(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'd0, 0, 0, 0, 32'd0, 1'b0,
               1'b1, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b1);
        run_op(1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'd0, 0, 0, 0, 32'd0, 1'b0,
               1'b1, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b1);
        run_op(1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'd0, 0, 0, 0, 32'd0, 1'b0,
               1'b1, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b1);
        run_op(1'b1, 1'b0, 3'b010, 32'h2000_0008, 32'd0, 3, 5, 4, 32'h0BAD_F00D, 1'b0,
               1'b1, 32'h2000_0008, 32'd0, 4'b0000, 32'h0BAD_F00D, 1'b0);
        run_op(1'b1, 1'b0, 3'b010, 32'h2000_000C, 32'd0, 1, 2, 1, 32'h1111_2222, 1'b1,
               1'b1, 32'h2000_000C, 32'd0, 4'b0000, 32'd0, 1'b1);
        run_op(1'b0, 1'b0, 3'b010, 32'h2000_0010, 32'd0, 0, 0, 2, 32'd0, 1'b0,
               1'b1, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b0);

        // timeout instance: no grant; grant on the last allowed cycle; grant then silence
        t4_op(4, 1'b0, 0, 1'b0, 1'b1, 32'd0);
        t4_op(4, 1'b1, 1, 1'b1, 1'b0, 32'hCAFE_0123);
        t4_op(2, 1'b1, 2, 1'b0, 1'b1, 32'd0);

        // reset while waiting for the response
        bif.i_valid = 1'b1; bif.i_ren = 1'b1; bif.i_wen = 1'b0;
        bif.i_type = 3'b010; bif.i_addr = 32'h0000_0040;
        e_ready = 1'b1; e_valid = 1'b0; e_req = 1'b0;
        @(posedge clk); #1;
        bif.i_valid = 1'b0; bif.i_mem_gnt = 1'b1;
        e_ready = 1'b0; e_req = 1'b1; e_we = 1'b0; e_maddr = 32'h0000_0040; e_wmask = 4'b0000;
        @(posedge clk); #1;
        bif.i_mem_gnt = 1'b0;
        e_req = 1'b0;
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_wait_mem_req", 32'(bif.o_mem_req), 32'd0);
        chk("rst_wait_valid", 32'(bif.o_valid), 32'd0);
        chk("rst_wait_err", 32'(bif.o_err), 32'd0);
        chk("rst_wait_ready", 32'(bif.o_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        bif.i_mem_rvalid = 1'b1;
        bif.i_mem_rdata  = 32'h5555_AAAA;
        e_ready = 1'b1; e_valid = 1'b0; e_req = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        bif.i_mem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("late_rvalid_valid", 32'(bif.o_valid), 32'd0);
        @(posedge clk); #1;

        // randomized operations
        for (int i = 0; i < 150; i++) begin
            r_sel = $urandom_range(0, 9);
            r_ren = (r_sel < 5);
            r_wen = (r_sel >= 5 && r_sel < 9);
            if (r_sel == 9) begin
                r_ren = 1'($urandom_range(0, 1));
                r_wen = 1'($urandom_range(0, 1));
            end
            r_ty = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) r_ty = {1'($urandom_range(0, 1)) & r_ren, 2'($urandom_range(0, 2))};
            r_addr = $urandom;
            if ($urandom_range(0, 1) == 0) r_addr[1:0] = 2'b00;
            r_wd   = $urandom;
            r_word = $urandom;
            r_g    = $urandom_range(0, 3);
            r_r    = $urandom_range(0, 5);
            r_d    = $urandom_range(0, 4);
            r_merr = ($urandom_range(0, 7) == 0);
            run_op(r_ren, r_wen, r_ty, r_addr, r_wd, r_g, r_r, r_d, r_word, r_merr,
                   1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
